// File: rtl/mem_stage_pkg.sv
// Shared widths, bubble tag and pipeline-register layouts for the memory stage.
package mem_stage_pkg;

  localparam int DATA_W        = 32;
  localparam int REG_AW        = 5;
  localparam int TAG_W         = 4;
  localparam int DM_AW_DEFAULT = 6;

  // Debug tag carried by a bubble.
  localparam logic [TAG_W-1:0] NOP_TAG = '0;

  // EX/MEM pipeline register contents.
  typedef struct packed {
    logic              wreg;
    logic              m2reg;
    logic              wmem;
    logic              branch;
    logic              zero;
    logic [DATA_W-1:0] alu_r;
    logic [DATA_W-1:0] in_b;
    logic [DATA_W-1:0] pc;
    logic [REG_AW-1:0] dest_r;
    logic [TAG_W-1:0]  ins_type;
    logic [TAG_W-1:0]  ins_number;
  } ex_mem_t;

  // MEM/WB pipeline register contents.
  typedef struct packed {
    logic              wreg;
    logic [REG_AW-1:0] dest_r;
    logic [DATA_W-1:0] dest;
    logic [TAG_W-1:0]  ins_type;
    logic [TAG_W-1:0]  ins_number;
  } mem_wb_t;

  // A branch in MEM redirects fetch only when its compare came out equal.
  function automatic logic branch_taken(input ex_mem_t r);
    return r.branch & r.zero;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX -> MEM inputs and the MEM/WB outputs (forwarding, branch redirect, tags).
interface mem_stage_if;
  import mem_stage_pkg::*;

  // Driven by the execute stage.
  logic              ex_wreg;
  logic              ex_m2reg;
  logic              ex_wmem;
  logic [DATA_W-1:0] ex_aluR;
  logic [DATA_W-1:0] ex_inB;
  logic [REG_AW-1:0] ex_destR;
  logic              ex_branch;
  logic [DATA_W-1:0] ex_pc;
  logic              ex_zero;
  logic [TAG_W-1:0]  EXE_ins_type;
  logic [TAG_W-1:0]  EXE_ins_number;

  // Produced by the memory stage.
  logic [DATA_W-1:0] mem_aluR;
  logic [REG_AW-1:0] mem_destR;
  logic              mem_wreg;
  logic              mem_m2reg;
  logic              mem_pcsrc;
  logic [DATA_W-1:0] mem_bpc;
  logic              wb_wreg;
  logic [REG_AW-1:0] wb_destR;
  logic [DATA_W-1:0] wb_dest;
  logic [TAG_W-1:0]  MEM_ins_type;
  logic [TAG_W-1:0]  MEM_ins_number;
  logic [TAG_W-1:0]  WB_ins_type;
  logic [TAG_W-1:0]  WB_ins_number;

  // Surrounding pipeline side.
  modport master (
    output ex_wreg, ex_m2reg, ex_wmem, ex_aluR, ex_inB, ex_destR,
           ex_branch, ex_pc, ex_zero, EXE_ins_type, EXE_ins_number,
    input  mem_aluR, mem_destR, mem_wreg, mem_m2reg, mem_pcsrc, mem_bpc,
           wb_wreg, wb_destR, wb_dest,
           MEM_ins_type, MEM_ins_number, WB_ins_type, WB_ins_number
  );

  // Memory-stage side.
  modport slave (
    input  ex_wreg, ex_m2reg, ex_wmem, ex_aluR, ex_inB, ex_destR,
           ex_branch, ex_pc, ex_zero, EXE_ins_type, EXE_ins_number,
    output mem_aluR, mem_destR, mem_wreg, mem_m2reg, mem_pcsrc, mem_bpc,
           wb_wreg, wb_destR, wb_dest,
           MEM_ins_type, MEM_ins_number, WB_ins_type, WB_ins_number
  );

endinterface

// File: rtl/mem_stage_data_mem.sv
// Word-addressed data memory: one synchronous write port, two combinational
// read ports (pipeline and debug).
module data_mem
  import mem_stage_pkg::*;
#(
  parameter int AW = DM_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr_a,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [AW-1:0]     addr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem_q [2**AW];

  // Store port: write the addressed word at the rising edge.
  // NOTE: the array deliberately has no reset; clearing it would need a
  // per-word reset path and program data must survive a pipeline reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr_a] <= wdata;
    end
  end

  assign rdata_a = mem_q[addr_a];
  assign rdata_b = mem_q[addr_b];

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: EX/MEM register, data memory, branch resolution with
// wrong-path squash, and MEM/WB register feeding write-back and forwarding.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DM_AW = DM_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_stage_if.slave        bus,
  input  logic [DM_AW-1:0]  dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  ex_mem_t           ex_mem_d, ex_mem_q;
  mem_wb_t           mem_wb_d, mem_wb_q;
  logic              pcsrc;
  logic [DATA_W-1:0] mdata;
  logic [DM_AW-1:0]  word_idx;

  assign pcsrc = branch_taken(ex_mem_q);

  // Byte offset dropped; address bits above the memory depth alias.
  assign word_idx = ex_mem_q.alu_r[DM_AW+1:2];

  data_mem #(.AW(DM_AW)) u_data_mem (
    .clk     (clk),
    .we      (ex_mem_q.wmem),
    .addr_a  (word_idx),
    .wdata   (ex_mem_q.in_b),
    .rdata_a (mdata),
    .addr_b  (dbg_addr),
    .rdata_b (dbg_data)
  );

  // EX/MEM next value: capture EX, turning it into a bubble behind a taken branch.
  // NOTE: every field gets its default before any condition so no path can
  // leave a field unassigned and infer a latch.
  always_comb begin
    ex_mem_d.wreg       = bus.ex_wreg;
    ex_mem_d.m2reg      = bus.ex_m2reg;
    ex_mem_d.wmem       = bus.ex_wmem;
    ex_mem_d.branch     = bus.ex_branch;
    ex_mem_d.zero       = bus.ex_zero;
    ex_mem_d.alu_r      = bus.ex_aluR;
    ex_mem_d.in_b       = bus.ex_inB;
    ex_mem_d.pc         = bus.ex_pc;
    ex_mem_d.dest_r     = bus.ex_destR;
    ex_mem_d.ins_type   = bus.EXE_ins_type;
    ex_mem_d.ins_number = bus.EXE_ins_number;
    if (pcsrc) begin
      // Data fields still load; without control bits they are inert.
      ex_mem_d.wreg       = 1'b0;
      ex_mem_d.m2reg      = 1'b0;
      ex_mem_d.wmem       = 1'b0;
      ex_mem_d.branch     = 1'b0;
      ex_mem_d.ins_type   = NOP_TAG;
      ex_mem_d.ins_number = NOP_TAG;
    end
  end

  // MEM/WB next value: loads take the memory word, everything else the ALU result.
  always_comb begin
    mem_wb_d.wreg       = ex_mem_q.wreg;
    mem_wb_d.dest_r     = ex_mem_q.dest_r;
    mem_wb_d.dest       = ex_mem_q.m2reg ? mdata : ex_mem_q.alu_r;
    mem_wb_d.ins_type   = ex_mem_q.ins_type;
    mem_wb_d.ins_number = ex_mem_q.ins_number;
  end

  // Both pipeline registers; reset empties them to bubbles at once, which
  // also cancels a store waiting in MEM.
  // NOTE: non-blocking assignments so every register samples the values from
  // before this edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  assign bus.mem_aluR       = ex_mem_q.alu_r;
  assign bus.mem_destR      = ex_mem_q.dest_r;
  assign bus.mem_wreg       = ex_mem_q.wreg;
  assign bus.mem_m2reg      = ex_mem_q.m2reg;
  assign bus.mem_pcsrc      = pcsrc;
  assign bus.mem_bpc        = ex_mem_q.pc;
  assign bus.MEM_ins_type   = ex_mem_q.ins_type;
  assign bus.MEM_ins_number = ex_mem_q.ins_number;

  assign bus.wb_wreg        = mem_wb_q.wreg;
  assign bus.wb_destR       = mem_wb_q.dest_r;
  assign bus.wb_dest        = mem_wb_q.dest;
  assign bus.WB_ins_type    = mem_wb_q.ins_type;
  assign bus.WB_ins_number  = mem_wb_q.ins_number;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table, directed corner sequences,
// and random instruction streams against a program-order reference model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int AW    = DM_AW_DEFAULT;
  localparam int DEPTH = 1 << AW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [AW-1:0]     dbg_addr = '0;
  logic [DATA_W-1:0] dbg_data;

  mem_stage_if bus ();

  mem_stage #(.DM_AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        wreg, m2reg, wmem, branch, zero;
    logic [31:0] alu, inb, pc;
    logic [4:0]  dest;
    logic [3:0]  ty, num;
  } instr_t;

  typedef struct {
    instr_t      in;
    logic [31:0] e_mem_alu;
    logic        e_mem_wreg;
    logic        e_pcsrc;
    logic [31:0] e_bpc;
    logic        e_wb_wreg;
    logic [31:0] e_wb_dest;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic instr_t mk(input logic wreg, m2reg, wmem, branch, zero,
                                input logic [31:0] alu, inb, pc,
                                input logic [4:0] dest, input logic [3:0] ty, num);
    instr_t i;
    i.wreg = wreg; i.m2reg = m2reg; i.wmem = wmem; i.branch = branch; i.zero = zero;
    i.alu = alu; i.inb = inb; i.pc = pc; i.dest = dest; i.ty = ty; i.num = num;
    return i;
  endfunction

  function automatic instr_t nop_i();
    return mk(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 4'd0, 4'd0);
  endfunction

  function automatic instr_t st_i(input logic [31:0] addr, data);
    return mk(0, 0, 1, 0, 0, addr, data, 32'h0, 5'd0, 4'd2, 4'd1);
  endfunction

  function automatic instr_t ld_i(input logic [31:0] addr, input logic [4:0] dest);
    return mk(1, 1, 0, 0, 0, addr, 32'h0, 32'h0, dest, 4'd1, 4'd2);
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    i = mk(0, 0, 0, 0, 1'($urandom), $urandom, $urandom, $urandom,
           5'($urandom), 4'($urandom), 4'($urandom));
    case ($urandom_range(0, 3))
      0:       i.wreg = 1'($urandom);
      1:       begin i.m2reg = 1'b1; i.wreg = 1'b1; end
      2:       i.wmem = 1'b1;
      default: i.branch = 1'b1;
    endcase
    return i;
  endfunction

  task automatic drive(input instr_t i);
    @(negedge clk);
    bus.ex_wreg        = i.wreg;
    bus.ex_m2reg       = i.m2reg;
    bus.ex_wmem        = i.wmem;
    bus.ex_branch      = i.branch;
    bus.ex_zero        = i.zero;
    bus.ex_aluR        = i.alu;
    bus.ex_inB         = i.inb;
    bus.ex_pc          = i.pc;
    bus.ex_destR       = i.dest;
    bus.EXE_ins_type   = i.ty;
    bus.EXE_ins_number = i.num;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input instr_t i);
    drive(i);
    tick();
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, " mem_aluR"},  bus.mem_aluR, 32'h0);
    check({pfx, " mem_destR"}, 32'(bus.mem_destR), 32'h0);
    check({pfx, " mem_wreg"},  32'(bus.mem_wreg), 32'h0);
    check({pfx, " mem_m2reg"}, 32'(bus.mem_m2reg), 32'h0);
    check({pfx, " mem_pcsrc"}, 32'(bus.mem_pcsrc), 32'h0);
    check({pfx, " mem_bpc"},   bus.mem_bpc, 32'h0);
    check({pfx, " wb_wreg"},   32'(bus.wb_wreg), 32'h0);
    check({pfx, " wb_destR"},  32'(bus.wb_destR), 32'h0);
    check({pfx, " wb_dest"},   bus.wb_dest, 32'h0);
    check({pfx, " mem_tags"},  32'({bus.MEM_ins_type, bus.MEM_ins_number}), 32'h0);
    check({pfx, " wb_tags"},   32'({bus.WB_ins_type, bus.WB_ins_number}), 32'h0);
  endtask

  // Reset with NOPs on the inputs so the first edge after release captures a bubble.
  task automatic pulse_reset();
    drive(nop_i());
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- reference model (program order) ----------------
  logic [31:0] mdl_mem   [DEPTH];
  bit          mdl_valid [DEPTH];
  instr_t      prev_eff;
  logic [31:0] prev_ld;
  bit          prev_ld_ok;
  bit          prev_taken;
  bit          pend_we;
  int          pend_idx;
  logic [31:0] pend_data;

  task automatic model_reset();
    for (int w = 0; w < DEPTH; w++) mdl_valid[w] = 1'b0;
    prev_eff   = nop_i();
    prev_ld    = '0;
    prev_ld_ok = 1'b0;
    prev_taken = 1'b0;
    pend_we    = 1'b0;
    pend_idx   = 0;
    pend_data  = '0;
  endtask

  // One instruction enters MEM; the previous one moves to WB.
  task automatic model_step(input instr_t i);
    instr_t      e;
    int          idx;
    logic [31:0] ld;
    e = i;
    if (prev_taken) begin
      e.wreg = 0; e.m2reg = 0; e.wmem = 0; e.branch = 0; e.ty = 0; e.num = 0;
    end
    drive(i);
    dbg_addr = AW'($urandom);
    tick();
    // The previous instruction's store lands on this edge.
    if (pend_we) begin
      mdl_mem[pend_idx]   = pend_data;
      mdl_valid[pend_idx] = 1'b1;
    end
    idx = int'((i.alu / 32'd4) % 32'(DEPTH));
    ld  = mdl_mem[idx];

    check("rnd mem_aluR",  bus.mem_aluR, i.alu);
    check("rnd mem_destR", 32'(bus.mem_destR), 32'(i.dest));
    check("rnd mem_wreg",  32'(bus.mem_wreg), 32'(e.wreg));
    check("rnd mem_m2reg", 32'(bus.mem_m2reg), 32'(e.m2reg));
    check("rnd mem_pcsrc", 32'(bus.mem_pcsrc), 32'(e.branch && e.zero));
    if (e.branch && e.zero) check("rnd mem_bpc", bus.mem_bpc, i.pc);
    check("rnd mem_tags", 32'({bus.MEM_ins_type, bus.MEM_ins_number}), 32'({e.ty, e.num}));
    check("rnd wb_wreg",  32'(bus.wb_wreg), 32'(prev_eff.wreg));
    check("rnd wb_destR", 32'(bus.wb_destR), 32'(prev_eff.dest));
    check("rnd wb_tags",  32'({bus.WB_ins_type, bus.WB_ins_number}), 32'({prev_eff.ty, prev_eff.num}));
    if (!prev_eff.m2reg)  check("rnd wb_dest alu", bus.wb_dest, prev_eff.alu);
    else if (prev_ld_ok)  check("rnd wb_dest load", bus.wb_dest, prev_ld);
    if (mdl_valid[dbg_addr]) check("rnd dbg_data", dbg_data, mdl_mem[dbg_addr]);

    pend_we    = e.wmem;
    pend_idx   = idx;
    pend_data  = i.inb;
    prev_eff   = e;
    prev_ld    = ld;
    prev_ld_ok = mdl_valid[idx];
    prev_taken = e.branch && e.zero;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs [5];

    vecs[0] = '{mk(1, 0, 0, 0, 0, 32'h0000_1234, 32'h0, 32'h0, 5'd3, 4'd4, 4'd1),
                32'h0000_1234, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_1234};
    vecs[1] = '{mk(0, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd31, 4'd15, 4'd15),
                32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 1'b0, 32'hFFFF_FFFF};
    vecs[2] = '{mk(0, 0, 0, 1, 1, 32'h0, 32'h0, 32'h0000_0040, 5'd0, 4'd3, 4'd2),
                32'h0, 1'b0, 1'b1, 32'h0000_0040, 1'b0, 32'h0};
    vecs[3] = '{mk(0, 0, 0, 1, 0, 32'h0000_0008, 32'h0, 32'h0000_0080, 5'd0, 4'd3, 4'd3),
                32'h0000_0008, 1'b0, 1'b0, 32'h0000_0080, 1'b0, 32'h0000_0008};
    vecs[4] = '{mk(1, 0, 0, 0, 1, 32'h8000_0001, 32'h0, 32'h0000_00C0, 5'd17, 4'd6, 4'd9),
                32'h8000_0001, 1'b1, 1'b0, 32'h0000_00C0, 1'b1, 32'h8000_0001};

    // Reset state.
    drive(nop_i());
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table: instruction, then a NOP to push it to WB.
    for (int k = 0; k < 5; k++) begin
      step(vecs[k].in);
      check($sformatf("v%0d mem_aluR", k),  bus.mem_aluR, vecs[k].e_mem_alu);
      check($sformatf("v%0d mem_wreg", k),  32'(bus.mem_wreg), 32'(vecs[k].e_mem_wreg));
      check($sformatf("v%0d mem_pcsrc", k), 32'(bus.mem_pcsrc), 32'(vecs[k].e_pcsrc));
      check($sformatf("v%0d mem_bpc", k),   bus.mem_bpc, vecs[k].e_bpc);
      check($sformatf("v%0d mem_destR", k), 32'(bus.mem_destR), 32'(vecs[k].in.dest));
      check($sformatf("v%0d mem_tags", k),  32'({bus.MEM_ins_type, bus.MEM_ins_number}),
            32'({vecs[k].in.ty, vecs[k].in.num}));
      step(nop_i());
      check($sformatf("v%0d wb_wreg", k),   32'(bus.wb_wreg), 32'(vecs[k].e_wb_wreg));
      check($sformatf("v%0d wb_dest", k),   bus.wb_dest, vecs[k].e_wb_dest);
      check($sformatf("v%0d wb_tags", k),   32'({bus.WB_ins_type, bus.WB_ins_number}),
            32'({vecs[k].in.ty, vecs[k].in.num}));
    end

    // Store then load of the same word.
    step(st_i(32'h10, 32'hDEAD_BEEF));
    step(ld_i(32'h10, 5'd5));
    check("sl mem_m2reg", 32'(bus.mem_m2reg), 32'h1);
    step(nop_i());
    check("sl wb_dest",  bus.wb_dest, 32'hDEAD_BEEF);
    check("sl wb_destR", 32'(bus.wb_destR), 32'd5);
    check("sl wb_wreg",  32'(bus.wb_wreg), 32'h1);

    // Taken branch squashes the following ALU op.
    step(mk(0, 0, 0, 1, 1, 32'h0, 32'h0, 32'h40, 5'd0, 4'd3, 4'd4));
    check("tb mem_pcsrc", 32'(bus.mem_pcsrc), 32'h1);
    check("tb mem_bpc",   bus.mem_bpc, 32'h40);
    step(mk(1, 0, 0, 0, 0, 32'h99, 32'h0, 32'h0, 5'd9, 4'd3, 4'd7));
    check("tb sq mem_pcsrc", 32'(bus.mem_pcsrc), 32'h0);
    check("tb sq mem_wreg",  32'(bus.mem_wreg), 32'h0);
    check("tb sq mem_tags",  32'({bus.MEM_ins_type, bus.MEM_ins_number}), 32'h0);
    check("tb sq mem_aluR",  bus.mem_aluR, 32'h99);
    check("tb br wb_tags",   32'({bus.WB_ins_type, bus.WB_ins_number}), 32'h34);
    step(nop_i());
    check("tb sq wb_wreg",   32'(bus.wb_wreg), 32'h0);

    // Not-taken branch lets the following ALU op through.
    step(mk(0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h40, 5'd0, 4'd3, 4'd5));
    check("nt mem_pcsrc", 32'(bus.mem_pcsrc), 32'h0);
    step(mk(1, 0, 0, 0, 0, 32'h77, 32'h0, 32'h0, 5'd4, 4'd5, 4'd2));
    check("nt mem_wreg", 32'(bus.mem_wreg), 32'h1);
    check("nt mem_tags", 32'({bus.MEM_ins_type, bus.MEM_ins_number}), 32'h52);
    step(nop_i());
    check("nt wb_wreg", 32'(bus.wb_wreg), 32'h1);
    check("nt wb_dest", bus.wb_dest, 32'h77);

    // Address aliasing and byte-offset masking; debug port sees old data until the edge.
    step(st_i(32'h004, 32'h11));
    dbg_addr = AW'(1);
    step(st_i(32'h104, 32'h55));
    check("wrap dbg old", dbg_data, 32'h11);
    step(ld_i(32'h007, 5'd7));
    check("wrap dbg new", dbg_data, 32'h55);
    step(nop_i());
    check("wrap wb_dest",  bus.wb_dest, 32'h55);
    check("wrap wb_destR", 32'(bus.wb_destR), 32'd7);

    // Reset mid-run with a store sitting in MEM and another on the inputs.
    step(st_i(32'h20, 32'h1111));
    step(st_i(32'h20, 32'h0BAD));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    tick();
    check_outputs_zero("midrst edge");
    dbg_addr = AW'(8);
    #1;
    check("midrst no write", dbg_data, 32'h1111);
    drive(nop_i());
    rst_n = 1'b1;

    // Random streams: fill memory through the pipeline, then mixed traffic.
    pulse_reset();
    model_reset();
    for (int w = 0; w < DEPTH; w++) model_step(st_i(32'(w * 4), $urandom));
    for (int n = 0; n < 400; n++) model_step(rand_instr());

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage pipelined CPU. Sits directly downstream of the execute stage.
- Holds the EX/MEM pipeline register, a word-addressed data memory and the MEM/WB pipeline register.
- Resolves branches and squashes the wrong-path instruction leaving EX.
- Sources both forwarding values back to EX:
  - mem_aluR: the EX/MEM result.
  - wb_dest: the MEM/WB write-back result.

Parameters:
- DM_AW, 6: data-memory word-address width (depth 2**DM_AW words of 32 bits).

Ports:
- clk  in  1  pipeline clock; all registers update on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_wreg  in  1  EX result writes the register file.
- ex_m2reg  in  1  EX instruction is a load.
- ex_wmem  in  1  EX instruction is a store.
- ex_aluR  in  32  ALU result / effective address.
- ex_inB  in  32  store data.
- ex_destR  in  5  destination register.
- ex_branch  in  1  EX instruction is a branch.
- ex_pc  in  32  branch target.
- ex_zero  in  1  ALU compare-equal flag.
- EXE_ins_type  in  4  debug tag, instruction type.
- EXE_ins_number  in  4  debug tag, instruction number.
- dbg_addr  in  DM_AW  debug read address into the data memory.
- mem_aluR  out  32  EX/MEM ALU result; forwarding source.
- mem_destR  out  5  EX/MEM destination register; used by forwarding compare.
- mem_wreg  out  1  EX/MEM register-write flag; used by forwarding compare.
- mem_m2reg  out  1  EX/MEM load flag; used by load-use hazard detection.
- mem_pcsrc  out  1  branch taken; the IF stage selects mem_bpc.
- mem_bpc  out  32  registered branch target.
- wb_wreg  out  1  MEM/WB register-write enable.
- wb_destR  out  5  MEM/WB destination register.
- wb_dest  out  32  MEM/WB write-back data; forwarding source.
- MEM_ins_type, MEM_ins_number  out  4 each  debug tags in MEM.
- WB_ins_type, WB_ins_number  out  4 each  debug tags in WB.
- dbg_data  out  32  combinational data-memory read at dbg_addr.

Behaviour:
- Reset (rst_n=0, asynchronous): every EX/MEM and MEM/WB field clears to 0.
  - All outputs above read 0, except dbg_data.
  - The pipeline therefore holds bubbles: no register write, no store, no branch.
  - Data-memory contents are not reset.
  - Reset mid-operation aborts any pending store: wmem is cleared before the next edge.
- EX/MEM register captures every EX input on each rising edge.
- Squash: if mem_pcsrc=1 at an edge, the EX/MEM load at that edge is a bubble.
  - wreg, m2reg, wmem, branch and the ins tags load 0.
  - aluR, inB, destR and pc load normally; they are don't-care.
- mem_pcsrc = mem_branch & mem_zero (combinational from EX/MEM).
  - It is high for exactly one cycle per taken branch, because the following load is squashed.
- Data memory:
  - Word index = mem_aluR[DM_AW+1:2]. Bits [1:0] are ignored; upper address bits alias (wrap).
  - Read is combinational: mdata = dm[index].
  - Write is synchronous: at the rising edge when mem_wmem=1, dm[index] <= mem_inB.
- Latency:
  - Store in MEM at cycle n: new value visible from cycle n+1.
  - Load in MEM at cycle n+1 to the same word returns the new value.
- MEM/WB register at each edge:
  - wb_wreg <= mem_wreg.
  - wb_destR <= mem_destR.
  - wb_dest <= mem_m2reg ? mdata : mem_aluR.
  - WB tags <= MEM tags.
- Squash never affects MEM/WB. The branch itself in MEM completes normally; branches have wreg=0.
- Store and dbg_addr to the same word in the same cycle: dbg_data shows the old value until the edge.

Decomposition:
- Shared package constants: DATA_W=32, REG_AW=5, TAG_W=4, the bubble/NOP tag value 0, and the default DM_AW.
- One sub-module: data_mem.
  - Synchronous write port.
  - Two combinational read ports: pipeline and debug.
- The pipeline registers stay inline in mem_stage.

Test Plan:
- Reset: drive rst_n=0 mid-run with ex_wmem=1 -> all outputs 0 immediately, mem_pcsrc=0, no memory write occurs.
- Store then load:
  - Store: ex_wmem=1, ex_aluR=0x10, ex_inB=0xDEADBEEF.
  - Next cycle load: ex_m2reg=1, ex_wreg=1, ex_aluR=0x10, ex_destR=5.
  - -> two edges after the load enters, wb_dest=0xDEADBEEF, wb_destR=5, wb_wreg=1.
- ALU pass-through: ex_wreg=1, ex_aluR=0x1234, ex_destR=3 -> mem_aluR=0x1234 after 1 edge; wb_dest=0x1234, wb_wreg=1 after 2 edges.
- Taken branch: ex_branch=1, ex_zero=1, ex_pc=0x40, followed by an ALU op with ex_wreg=1.
  - -> mem_pcsrc=1 and mem_bpc=0x40 for one cycle.
  - -> the following instruction reaches MEM with mem_wreg=0 and MEM tags 0.
  - -> wb_wreg stays 0 for it.
- Not-taken branch: ex_branch=1, ex_zero=0 -> mem_pcsrc=0; the next instruction is not squashed.
- Wrap/alignment with DM_AW=6:
  - Store to address 0x104 with data 0x55 -> dbg_addr=1 reads 0x55 (0x104 aliases word 1).
  - Load from address 0x007 -> returns dm[1] = 0x55.
